// File: rtl/db_mv_arb.sv
// Single-port MV RAM arbiter: posted-write FIFO with read-over-write priority,
// read/write address hazard blocking, and 1-cycle read return.
`ifndef FMV_WIDTH
`define FMV_WIDTH 16
`endif

module db_mv_arb #(
    parameter int unsigned DATA_WIDTH = 2*`FMV_WIDTH,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,

    input  logic                  rd_valid_i,
    output logic                  rd_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_dvalid_o,

    output logic                  ram_cen_o,
    output logic                  ram_wen_o,
    output logic                  ram_ren_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,

    output logic                  idle_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  dvalid_q;

    logic                  full;
    logic                  hazard;
    logic                  rd_fire;
    logic                  wr_fire;
    logic                  pop;
    logic [PTR_W-1:0]      offs;

    assign full = (count == CNT_W'(FIFO_DEPTH));

    // Hazard against entries occupied at cycle start (offset from head < count)
    always_comb begin
        hazard = 1'b0;
        offs   = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr;
            if ((CNT_W'(offs) < count) && (fifo_addr[i] == rd_addr_i)) begin
                hazard = 1'b1;
            end
        end
    end

    assign wr_ready_o = rst | ~full;
    assign rd_ready_o = rst | (~full & ~hazard);

    assign rd_fire = ~rst & rd_valid_i & ~full & ~hazard;
    assign wr_fire = ~rst & wr_valid_i & ~full;
    assign pop     = ~rst & ~rd_fire & (count != '0);

    // One RAM operation per cycle: a granted read wins, otherwise drain the head
    always_comb begin
        ram_cen_o  = 1'b1;
        ram_wen_o  = 1'b1;
        ram_addr_o = '0;
        ram_data_o = '0;
        if (rd_fire) begin
            ram_cen_o  = 1'b0;
            ram_addr_o = rd_addr_i;
        end else if (pop) begin
            ram_cen_o  = 1'b0;
            ram_wen_o  = 1'b0;
            ram_addr_o = fifo_addr[rd_ptr];
            ram_data_o = fifo_data[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            dvalid_q <= 1'b0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_fire, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            dvalid_q <= rd_fire;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            fifo_addr[wr_ptr] <= wr_addr_i;
            fifo_data[wr_ptr] <= wr_data_i;
        end
    end

    assign rd_dvalid_o = dvalid_q & ~rst;
    assign ram_ren_o   = ~rd_dvalid_o;
    assign rd_data_o   = rd_dvalid_o ? ram_data_i : '0;
    assign idle_o      = rst | ((count == '0) & ~dvalid_q);

endmodule

// File: doc/db_mv_arb.md
DB_MV_ARB -- requirements
Module: db_mv_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 2*`FMV_WIDTH, MV RAM word width (one packed MV pair).
REQ-002 Parameter ADDR_WIDTH, default 7, MV RAM address width.
REQ-003 Parameter FIFO_DEPTH, default 4, posted-write buffer depth; SHALL be a power of two >= 2.
REQ-004 Clock and reset SHALL be: clk input 1, the single clock; rst input 1, reset, synchronous and active-high.
REQ-005 Write requester ports SHALL be:
- wr_valid_i input 1, write request.
- wr_ready_o output 1, write accepted when high with wr_valid_i.
- wr_addr_i input ADDR_WIDTH, write address.
- wr_data_i input DATA_WIDTH, write data.
REQ-006 Read requester ports SHALL be:
- rd_valid_i input 1, read request.
- rd_ready_o output 1, read accepted when high with rd_valid_i.
- rd_addr_i input ADDR_WIDTH, read address.
- rd_data_o output DATA_WIDTH, read data.
- rd_dvalid_o output 1, rd_data_o valid.
REQ-007 RAM-side ports SHALL be:
- ram_cen_o output 1, chip enable, low active.
- ram_wen_o output 1, write enable, low active.
- ram_ren_o output 1, output enable, low active.
- ram_addr_o output ADDR_WIDTH, address.
- ram_data_o output DATA_WIDTH, write data.
- ram_data_i input DATA_WIDTH, RAM read data.
REQ-008 idle_o output 1, high when the FIFO is empty and no read is in flight.

Function
REQ-009 Accepted writes SHALL be posted into a FIFO_DEPTH-entry in-order FIFO (address and data); wr_ready_o SHALL equal (count < FIFO_DEPTH) using the registered count only.
REQ-010 The block SHALL issue at most one RAM operation (read or write) per cycle.
REQ-011 A hazard SHALL exist when rd_addr_i equals the address of any occupied FIFO entry.
REQ-012 rd_ready_o SHALL be high iff count < FIFO_DEPTH and no hazard.
REQ-013 A read handshake SHALL grant the RAM to the read in that cycle: ram_cen_o=0, ram_wen_o=1, ram_addr_o=rd_addr_i.
REQ-014 When no read is granted and count > 0, the head FIFO entry SHALL be popped and written: ram_cen_o=0, ram_wen_o=0, ram_addr_o/ram_data_o=head entry.
REQ-015 When FIFO is full, the write drain SHALL take priority and rd_ready_o SHALL be 0.
REQ-016 With no operation, the block SHALL drive ram_cen_o=1, ram_wen_o=1, ram_addr_o=0, ram_data_o=0.
REQ-017 Read latency SHALL be 1 cycle: rd_dvalid_o registered high the cycle after a read grant; ram_ren_o = ~rd_dvalid_o.
REQ-018 rd_data_o SHALL equal ram_data_i when rd_dvalid_o=1 and 0 otherwise.
REQ-019 Back-to-back reads SHALL be accepted every cycle while no hazard exists, with rd_dvalid_o continuously high.
REQ-020 For a read and a write accepted in the same cycle, the read SHALL be ordered first and return pre-write data.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 Pushing into an empty FIFO SHALL not write the RAM in the same cycle; the earliest write is the next cycle.
REQ-023 Hazard comparison SHALL use only entries occupied at the start of the cycle.
REQ-024 idle_o SHALL be registered-state-derived: count==0 and rd_dvalid_o==0.

Reset
REQ-025 While rst=1, the block SHALL set FIFO count and pointers to 0, rd_dvalid_o=0, rd_data_o=0.
REQ-026 While rst=1, RAM outputs SHALL be in the no-operation state of REQ-016, with ram_ren_o=1.
REQ-027 While rst=1, wr_ready_o, rd_ready_o and idle_o SHALL take their values for an empty FIFO, i.e. 1, 1 and 1.
REQ-028 Reset asserted mid-operation SHALL discard all posted writes and any in-flight read with no RAM write issued that cycle.

Verification
REQ-029 Burst test: 5 writes on consecutive cycles (addr 0..4, data 0xA0..0xA4) with no reads -> wr_ready_o=0 on the 5th request cycle only if 4 entries are still pending; all 5 words written in order; idle_o=1 afterwards.
REQ-030 Read latency: write addr 7=0x55, drain, then read addr 7 -> rd_dvalid_o=1 and rd_data_o=0x55 exactly one cycle after the handshake, with ram_ren_o=0 in that cycle.
REQ-031 Hazard: post write addr 3=0x12 while read addr 3 is continuously requested -> rd_ready_o=0 until the write pops; the read then returns 0x12.
REQ-032 Simultaneous: with an empty FIFO, write addr 9=0x77 and read addr 9 (old 0x01) in the same cycle -> the read returns 0x01, then the RAM holds 0x77.
REQ-033 Full priority: fill 4 entries while issuing reads -> rd_ready_o=0 until count<4; a write is issued on the RAM every such cycle.
REQ-034 Reset mid-burst: assert rst with 3 posted writes -> no further RAM writes; wr_ready_o=1 and idle_o=1 the cycle after reset.
